score_counter: RTL and testbench
================================

// Module: score_counter
// PURPOSE
//   Downstream of the player controller: turns its game_start_pulse / game_over_pulse and
//   game_tick into a running BCD score for the display stage. Score advances with elapsed
//   play time, freezes at game over, and raises a milestone pulse every 100 points for the
//   obstacle-speed logic. High-score tracking is optional.
// PARAMETERS
//   DIGITS           4   number of BCD digits in the score (>=3)
//   TICKS_PER_POINT  8   game_tick[0] pulses per +1 score (>=1)
// PORTS
//   clk               in   1          system clock, rising edge
//   rst_n             in   1          asynchronous active-low reset
//   game_tick         in   2          frame ticks; only bit 0 is used here
//   game_start_pulse  in   1          1-cycle: new game begins
//   game_over_pulse   in   1          1-cycle: player crashed
//   game_frozen       in   1          level: pause, ticks ignored while high
//   score_bcd         out  4*DIGITS   current score, digit 0 in [3:0]
//   high_score_bcd    out  4*DIGITS   best score since reset (0 without HIGH_SCORE_EN)
//   milestone_pulse   out  1          1-cycle: score just reached a multiple of 100
//   score_saturated   out  1          level: score is all 9s
//   new_high_score    out  1          1-cycle: high score just updated
// BEHAVIOUR
//   - All state and outputs are registered. rst_n low clears everything to 0 immediately,
//     including mid-count, and puts the FSM in IDLE.
//   - FSM states are IDLE, COUNTING and FROZEN.
//     IDLE -> COUNTING on game_start_pulse.
//     COUNTING -> FROZEN on game_over_pulse.
//     FROZEN -> COUNTING on game_start_pulse.
//   - On game_start_pulse, in any state: score <= 0, prescaler <= 0, milestone and
//     saturated flags cleared. high_score is NOT cleared.
//   - game_start_pulse and game_over_pulse in the same cycle: start wins.
//   - In COUNTING, a cycle with game_tick[0]=1 and game_frozen=0 is a valid tick.
//     - Prescaler counts 0..TICKS_PER_POINT-1.
//     - On a valid tick with prescaler == TICKS_PER_POINT-1: prescaler wraps to 0 and the
//       score increments by 1.
//     - Latency: the new score is visible the cycle after the tick.
//   - BCD increment: digit 0 +1; any digit that would reach 10 becomes 0 and carries into
//     the next digit. No digit ever holds A-F.
//   - Saturation: at all 9s the score holds and score_saturated=1. The prescaler keeps
//     running but the score never changes.
//   - milestone_pulse is high for exactly the cycle in which score_bcd first shows a value
//     with digits [1:0]=00 and score != 0. It is never raised at start/clear or while
//     saturated.
//   - game_over_pulse coinciding with a point-completing tick: game over wins and the
//     score is not incremented.
//   - In IDLE and FROZEN, ticks are ignored and the score holds.
//   - game_over_pulse in IDLE or FROZEN is ignored. The FSM stays in its current state.
//   - game_frozen high in COUNTING suspends the prescaler. The count resumes from the same
//     prescaler value when game_frozen drops.
// CONFIGURATION
//   HIGH_SCORE_EN defined:
//     - On a game_over_pulse accepted in COUNTING, if score > high_score (BCD magnitude
//       compare), high_score <= score.
//     - new_high_score pulses in the same cycle high_score_bcd shows the new value, which
//       is the cycle after game_over_pulse.
//     - A score equal to the high score does not update it and does not pulse.
//     - high_score_bcd is cleared only by rst_n.
//   HIGH_SCORE_EN undefined:
//     - No high-score register or comparator is built.
//     - high_score_bcd = 0 and new_high_score = 0 permanently. Ports still exist.
// TESTING (DIGITS=4, TICKS_PER_POINT=8)
//   1. rst_n low, then 20 ticks with no start -> score 0000, all pulses 0, FSM stays IDLE.
//   2. start, then 8 valid ticks -> score 0001 one cycle after the 8th tick.
//      Continue to 800 ticks -> 0100, with milestone_pulse high for exactly 1 cycle.
//   3. Force score 0999 and one point -> 1000 (triple carry).
//      From 9998: two points -> 9999 with score_saturated=1, then 16 more ticks -> still
//      9999 and no milestone.
//   4. Scenario A: 7 ticks, then game_over_pulse together with the 8th tick -> score stays
//      0000 and FSM is FROZEN; later ticks do not change it.
//      Scenario B: start and over together -> score cleared, FSM is COUNTING.
//   5. game_frozen=1 for 10 ticks after 5 ticks -> no increment. Release, then 3 more
//      ticks -> score 0001.
//   6. HIGH_SCORE_EN:
//      - game 1 ends at 0042 -> high 0042 and new_high_score 1 pulse.
//      - game 2 ends at 0017 -> high stays 0042, no pulse; start cleared score only.
//      Without the macro: high_score_bcd=0000 and no pulse throughout.

Source files
------------

// File: rtl/score_counter.sv
// Running BCD score driven by game ticks, with a milestone pulse every 100 points.
// Define HIGH_SCORE_EN to build the best-score register and its update pulse.
module score_counter #(
  parameter int DIGITS          = 4,
  parameter int TICKS_PER_POINT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            game_tick,
  input  logic                  game_start_pulse,
  input  logic                  game_over_pulse,
  input  logic                  game_frozen,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   high_score_bcd,
  output logic                  milestone_pulse,
  output logic                  score_saturated,
  output logic                  new_high_score
);

  localparam int SW = 4 * DIGITS;
  localparam int PW = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICKS_PER_POINT - 1);
  localparam logic [SW-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, COUNTING, FROZEN} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   prescaler_q, prescaler_d;
  logic [SW-1:0]   score_q, score_d;
  logic            milestone_q, milestone_d;
  logic            saturated_q, saturated_d;
  logic            countEn, overAccepted;
  logic            validTick, pointDone;
  logic            unusedTickHi;

  assign unusedTickHi = game_tick[1];

  function automatic logic [SW-1:0] bcdInc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Start has priority over everything, including a simultaneous game over.
  always_comb begin
    state_d = state_q;
    if (game_start_pulse) begin
      state_d = COUNTING;
    end else if (overAccepted) begin
      state_d = FROZEN;
    end
  end

  always_comb begin
    countEn      = 1'b0;
    overAccepted = 1'b0;
    if (state_q == COUNTING && !game_start_pulse) begin
      countEn      = !game_over_pulse;
      overAccepted = game_over_pulse;
    end
  end

  assign validTick = countEn && game_tick[0] && !game_frozen;
  assign pointDone = validTick && (prescaler_q == PRE_LAST);

  // The prescaler keeps wrapping at saturation; only the score is held.
  always_comb begin
    prescaler_d = prescaler_q;
    score_d     = score_q;
    milestone_d = 1'b0;
    if (game_start_pulse) begin
      prescaler_d = '0;
      score_d     = '0;
    end else if (validTick) begin
      prescaler_d = pointDone ? '0 : prescaler_q + 1'b1;
      if (pointDone && !saturated_q) begin
        score_d     = bcdInc(score_q);
        milestone_d = (score_d[7:0] == 8'h00);
      end
    end
    saturated_d = (score_d == ALL_NINES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      score_q     <= '0;
      milestone_q <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      score_q     <= score_d;
      milestone_q <= milestone_d;
      saturated_q <= saturated_d;
    end
  end

  assign score_bcd       = score_q;
  assign milestone_pulse = milestone_q;
  assign score_saturated = saturated_q;

`ifdef HIGH_SCORE_EN
  logic [SW-1:0] highScore_q, highScore_d;
  logic          newHigh_q, newHigh_d;

  // Packed BCD with valid digits orders the same as plain unsigned compare.
  always_comb begin
    highScore_d = highScore_q;
    newHigh_d   = 1'b0;
    if (overAccepted && (score_q > highScore_q)) begin
      highScore_d = score_q;
      newHigh_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      highScore_q <= '0;
      newHigh_q   <= 1'b0;
    end else begin
      highScore_q <= highScore_d;
      newHigh_q   <= newHigh_d;
    end
  end

  assign high_score_bcd = highScore_q;
  assign new_high_score = newHigh_q;
`else
  assign high_score_bcd = '0;
  assign new_high_score = 1'b0;
`endif

endmodule

// File: tb/tb_score_counter.sv
// Self-checking bench for score_counter: two instances (8 and 2 ticks per point)
// share one stimulus stream and are compared every cycle against an integer model.
module tb_score_counter;

  localparam int TPP_A = 8;
  localparam int TPP_B = 2;
  localparam int MAXS  = 9999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  game_tick = 2'b00;
  logic        start = 1'b0;
  logic        over = 1'b0;
  logic        frozen = 1'b0;

  logic [15:0] scoreA, highA, scoreB, highB;
  logic        mileA, satA, newA, mileB, satB, newB;

  int total = 0;
  int bad   = 0;

  int mScore[2];
  int mPre[2];
  int mHigh[2];
  bit mPlay[2];
  bit mMile[2];
  bit mNew[2];

  score_counter #(.DIGITS(4), .TICKS_PER_POINT(TPP_A)) dutA (
    .clk(clk), .rst_n(rst_n), .game_tick(game_tick),
    .game_start_pulse(start), .game_over_pulse(over), .game_frozen(frozen),
    .score_bcd(scoreA), .high_score_bcd(highA), .milestone_pulse(mileA),
    .score_saturated(satA), .new_high_score(newA)
  );

  score_counter #(.DIGITS(4), .TICKS_PER_POINT(TPP_B)) dutB (
    .clk(clk), .rst_n(rst_n), .game_tick(game_tick),
    .game_start_pulse(start), .game_over_pulse(over), .game_frozen(frozen),
    .score_bcd(scoreB), .high_score_bcd(highB), .milestone_pulse(mileB),
    .score_saturated(satB), .new_high_score(newB)
  );

  always #5 clk = ~clk;

  function automatic int tppOf(input int i);
    return (i == 0) ? TPP_A : TPP_B;
  endfunction

  function automatic logic [15:0] toBcd(input int v);
    logic [15:0] r;
    int          t;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mScore[i] = 0; mPre[i] = 0; mHigh[i] = 0;
      mPlay[i] = 1'b0; mMile[i] = 1'b0; mNew[i] = 1'b0;
    end
  endtask

  // One rising edge of the game as seen from the rules: start wins, over ends play.
  task automatic modelClock();
    for (int i = 0; i < 2; i++) begin
      mMile[i] = 1'b0;
      mNew[i]  = 1'b0;
      if (start) begin
        mPlay[i] = 1'b1; mScore[i] = 0; mPre[i] = 0;
      end else if (mPlay[i]) begin
        if (over) begin
          mPlay[i] = 1'b0;
`ifdef HIGH_SCORE_EN
          if (mScore[i] > mHigh[i]) begin
            mHigh[i] = mScore[i];
            mNew[i]  = 1'b1;
          end
`endif
        end else if (game_tick[0] && !frozen) begin
          mPre[i]++;
          if (mPre[i] == tppOf(i)) begin
            mPre[i] = 0;
            if (mScore[i] < MAXS) begin
              mScore[i]++;
              mMile[i] = (mScore[i] % 100 == 0);
            end
          end
        end
      end
    end
  endtask

  task automatic checkOne(input string tag, input string what,
                          input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("[TB] FAIL %s %s got=%h want=%h", tag, what, got, want);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne(tag, "A.score", scoreA, toBcd(mScore[0]));
    checkOne(tag, "A.high",  highA,  toBcd(mHigh[0]));
    checkOne(tag, "A.mile",  {15'b0, mileA}, {15'b0, mMile[0]});
    checkOne(tag, "A.sat",   {15'b0, satA},  {15'b0, (mScore[0] == MAXS)});
    checkOne(tag, "A.newhi", {15'b0, newA},  {15'b0, mNew[0]});
    checkOne(tag, "B.score", scoreB, toBcd(mScore[1]));
    checkOne(tag, "B.high",  highB,  toBcd(mHigh[1]));
    checkOne(tag, "B.mile",  {15'b0, mileB}, {15'b0, mMile[1]});
    checkOne(tag, "B.sat",   {15'b0, satB},  {15'b0, (mScore[1] == MAXS)});
    checkOne(tag, "B.newhi", {15'b0, newB},  {15'b0, mNew[1]});
  endtask

  // Drives one cycle of inputs, clocks, updates the model and checks #1 after the edge.
  task automatic applyStimulus(input logic tick, input logic st, input logic ov,
                               input logic fr, input string tag);
    game_tick = {1'($urandom_range(0, 1)), tick};
    start     = st;
    over      = ov;
    frozen    = fr;
    @(posedge clk);
    if (rst_n) modelClock();
    else       modelReset();
    #1;
    start = 1'b0;
    over  = 1'b0;
    checkOutput(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic runRandom(input int n, input int tickPct, input int frzPct, input string tag);
    repeat (n)
      applyStimulus(($urandom % 100) < tickPct, 1'b0, 1'b0, ($urandom % 100) < frzPct, tag);
  endtask

  initial begin
    int guard;
    modelReset();
    #12;
    checkOutput("reset");
    ticks(3, "inReset");
    rst_n = 1'b1;
    ticks(20, "idleTicks");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, "idleOver");
    ticks(4, "idleAfterOver");

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "start1");
    ticks(8, "firstPoint");
    ticks(792, "toHundred");
    runRandom(200, 80, 10, "randomPlay");

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "startA");
    ticks(7, "scenA7");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, "scenAOverTick");
    ticks(10, "scenAFrozen");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, "scenBStartOver");
    ticks(5, "scenBCount");

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "startFreeze");
    ticks(5, "preFreeze");
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "frozen");
    ticks(3, "postFreeze");

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "game1");
    ticks(336, "game1Play");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "game1Over");
    ticks(3, "game1After");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "game2");
    ticks(136, "game2Play");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "game2Over");
    ticks(2, "game2After");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "game3");
    ticks(336, "game3Play");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "game3OverEqual");
    ticks(2, "game3After");

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "startReset");
    ticks(50, "preAsync");
    rst_n = 1'b0;
    #2;
    modelReset();
    checkOutput("asyncReset");
    ticks(2, "heldReset");
    rst_n = 1'b1;
    ticks(5, "afterReset");

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "startLong");
    guard = 0;
    while (mScore[1] < MAXS && guard < 40000) begin
      runRandom(1, 85, 5, "longRun");
      guard++;
    end
    if (guard >= 40000) begin
      total++;
      bad++;
      $display("[TB] FAIL longRun timeout got=%0d want=%0d", mScore[1], MAXS);
    end
    ticks(40, "saturated");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "longOver");
    ticks(3, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
